// File: rtl/ram_arb_pkg.sv
// Shared sizing and FSM encoding for the RAM port arbiter.
package ram_arb_pkg;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted most recently wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    import ram_arb_pkg::*;

    // High when requester 1 holds the most recent grant, so requester 0 is favoured.
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two write and two read requesters onto a dual-port RAM,
// zero-filling the RAM after reset or a clr pulse before serving requests.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    wreq,
    input  logic [AW-1:0] waddr0,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    wgnt,
    input  logic [1:0]    rreq,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [1:0]    rgnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    input  logic          clr,
    output logic          init_busy,
    output logic          ram_wr,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_dout
);
    import ram_arb_pkg::*;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic [1:0]    r_rvalid;
    logic          w_run;
    logic          w_en;
    logic [1:0]    w_wgnt;
    logic [1:0]    w_rgnt;

    assign w_run = (r_state == RUN);
    // Grants are withheld in the clr cycle so no read completes inside INIT.
    assign w_en  = w_run & ~clr;

    rr_arb2 u_warb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_req (wreq),
        .o_gnt (w_wgnt)
    );

    rr_arb2 u_rarb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_req (rreq),
        .o_gnt (w_rgnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= INIT;
            r_cnt    <= '0;
            r_rvalid <= 2'b00;
        end else begin
            r_rvalid <= w_rgnt;
            case (r_state)
                INIT: begin
                    if (clr) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == '1) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (clr) begin
                        r_state <= INIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // The reset input gates ram_wr directly so no write can slip out while reset is held.
    always_comb begin
        ram_wr     = 1'b0;
        ram_w_addr = waddr0;
        ram_din    = wdata0;
        if (!w_run) begin
            ram_wr     = rst;
            ram_w_addr = r_cnt;
            ram_din    = '0;
        end else if (|w_wgnt) begin
            ram_wr = 1'b1;
            if (w_wgnt[1]) begin
                ram_w_addr = waddr1;
                ram_din    = wdata1;
            end
        end
    end

    assign ram_r_addr = w_rgnt[1] ? raddr1 : raddr0;
    assign wgnt       = w_wgnt;
    assign rgnt       = w_rgnt;
    assign rvalid     = r_rvalid;
    assign rdata      = ram_dout;
    assign init_busy  = ~w_run;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wreq, rreq;
    logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          clr;
    logic [1:0]    wgnt, rgnt, rvalid;
    logic [DW-1:0] rdata;
    logic          initBusy;
    logic          ramWr;
    logic [AW-1:0] ramWAddr, ramRAddr;
    logic [DW-1:0] ramDin, ramDout;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wreq       (wreq),
        .waddr0     (waddr0),
        .waddr1     (waddr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .wgnt       (wgnt),
        .rreq       (rreq),
        .raddr0     (raddr0),
        .raddr1     (raddr1),
        .rgnt       (rgnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .clr        (clr),
        .init_busy  (initBusy),
        .ram_wr     (ramWr),
        .ram_w_addr (ramWAddr),
        .ram_din    (ramDin),
        .ram_r_addr (ramRAddr),
        .ram_dout   (ramDout)
    );

    // RAM behind the arbiter: synchronous write, registered read returning pre-write data.
    logic [DW-1:0] ramMem [DEPTH];
    always @(posedge clk) begin
        if (ramWr) ramMem[ramWAddr] <= ramDin;
        ramDout <= ramMem[ramRAddr];
    end

    // Reference model: memory contents, who was granted last on each port, pending read.
    logic [DW-1:0] shadow [DEPTH];
    logic          lastW, lastR;
    logic [1:0]    expRvalid;
    logic [DW-1:0] expRdata;

    typedef struct {
        logic [1:0] wr;
        logic [1:0] rr;
        logic [1:0] expW;
        logic [1:0] expR;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return last ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] wr, input logic [1:0] rr,
                                 input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                 input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wreq = wr;   rreq = rr;
        waddr0 = wa0; waddr1 = wa1;
        wdata0 = wd0; wdata1 = wd1;
        raddr0 = ra0; raddr1 = ra1;
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        lastW = 1'b1;
        lastR = 1'b1;
        expRvalid = 2'b00;
        expRdata  = '0;
    endtask

    // One RUN cycle: model predicts, DUT is compared at the falling edge.
    task automatic runCycle(input string tag, input logic tblValid, input logic [1:0] tblW,
                            input logic [1:0] tblR, input logic constValid, input logic [DW-1:0] constRd);
        logic [1:0]    eW, eR;
        logic [AW-1:0] eWa, eRa;
        logic [DW-1:0] eWd, nextRd;
        eW  = pick(wreq, lastW);
        eR  = pick(rreq, lastR);
        if (eW != 2'b00) lastW = eW[1];
        if (eR != 2'b00) lastR = eR[1];
        eWa = eW[1] ? waddr1 : waddr0;
        eWd = eW[1] ? wdata1 : wdata0;
        eRa = eR[1] ? raddr1 : raddr0;
        nextRd = shadow[eRa];
        @(negedge clk);
        checkOutput({tag, " wgnt"}, 32'(wgnt), 32'(tblValid ? tblW : eW));
        checkOutput({tag, " rgnt"}, 32'(rgnt), 32'(tblValid ? tblR : eR));
        checkOutput({tag, " rvalid"}, 32'(rvalid), 32'(expRvalid));
        if (expRvalid != 2'b00) checkOutput({tag, " rdata"}, 32'(rdata), 32'(expRdata));
        if (constValid) checkOutput({tag, " rdata const"}, 32'(rdata), 32'(constRd));
        checkOutput({tag, " ram_wr/busy"}, {30'd0, ramWr, initBusy}, {30'd0, |eW, 1'b0});
        if (eW != 2'b00) begin
            checkOutput({tag, " ram_w_addr"}, 32'(ramWAddr), 32'(eWa));
            checkOutput({tag, " ram_din"}, 32'(ramDin), 32'(eWd));
            shadow[eWa] = eWd;
        end
        if (eR != 2'b00) checkOutput({tag, " ram_r_addr"}, 32'(ramRAddr), 32'(eRa));
        @(posedge clk);
        expRvalid = eR;
        expRdata  = nextRd;
        #1;
    endtask

    // Checks `count` INIT cycles: zero written to ascending addresses, no grants.
    task automatic initSweep(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            checkOutput($sformatf("init sweep %0d", i),
                        {initBusy, ramWr, ramWAddr, ramDin, wgnt, rgnt, rvalid},
                        {1'b1, 1'b1, AW'(i), DW'(0), 2'b00, 2'b00, 2'b00});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b11, 2'b00, 2'b01, 2'b00};
        vecs[1] = '{2'b11, 2'b00, 2'b10, 2'b00};
        vecs[2] = '{2'b11, 2'b00, 2'b01, 2'b00};
        vecs[3] = '{2'b11, 2'b00, 2'b10, 2'b00};
        vecs[4] = '{2'b00, 2'b11, 2'b00, 2'b01};
        vecs[5] = '{2'b01, 2'b11, 2'b01, 2'b10};
        vecs[6] = '{2'b11, 2'b10, 2'b10, 2'b10};
        vecs[7] = '{2'b10, 2'b11, 2'b10, 2'b01};
        vecs[8] = '{2'b00, 2'b00, 2'b00, 2'b00};
        vecs[9] = '{2'b11, 2'b11, 2'b01, 2'b10};

        rst = 1'b0;
        clr = 1'b0;
        applyStimulus(2'b11, 2'b11, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        resetModel();

        // Reset state: requests present but nothing granted or written.
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset state", {27'd0, initBusy, ramWr, wgnt != 2'b00, rgnt != 2'b00, rvalid != 2'b00},
                    {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        initSweep(DEPTH);
        resetModel();

        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        runCycle("first run", 1'b0, 2'b00, 2'b00, 1'b0, '0);

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].wr, vecs[v].rr, 8'hA0, 8'hB1, 16'h1234, 16'h5678, 8'hC2, 8'hD3);
            runCycle($sformatf("vec %0d", v), 1'b1, vecs[v].expW, vecs[v].expR, 1'b0, '0);
        end

        // Write then read back through requester 1.
        applyStimulus(2'b01, 2'b00, 8'h12, 8'h00, 16'hBEEF, 16'h0, 8'h00, 8'h00);
        runCycle("wr 0x12", 1'b1, 2'b01, 2'b00, 1'b0, '0);
        applyStimulus(2'b00, 2'b10, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h12);
        runCycle("rd 0x12", 1'b1, 2'b00, 2'b10, 1'b0, '0);
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        runCycle("rd 0x12 data", 1'b0, 2'b00, 2'b00, 1'b1, 16'hBEEF);

        // Same-cycle write and read of one address returns the old data.
        applyStimulus(2'b01, 2'b01, 8'h34, 8'h00, 16'h1111, 16'h0, 8'h34, 8'h00);
        runCycle("wr+rd 0x34", 1'b1, 2'b01, 2'b01, 1'b0, '0);
        applyStimulus(2'b00, 2'b01, 8'h00, 8'h00, 16'h0, 16'h0, 8'h34, 8'h00);
        runCycle("rd 0x34 old", 1'b0, 2'b00, 2'b00, 1'b1, 16'h0000);
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        runCycle("rd 0x34 new", 1'b0, 2'b00, 2'b00, 1'b1, 16'h1111);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(2'($urandom), 2'($urandom),
                          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                          DW'($urandom), DW'($urandom),
                          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
            runCycle("random", 1'b0, 2'b00, 2'b00, 1'b0, '0);
        end
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        runCycle("drain", 1'b0, 2'b00, 2'b00, 1'b0, '0);

        // clr in RUN with both ports requesting: no grants, then a fresh sweep.
        applyStimulus(2'b11, 2'b11, 8'h05, 8'h06, 16'hAAAA, 16'h5555, 8'h07, 8'h08);
        clr = 1'b1;
        @(negedge clk);
        checkOutput("clr cycle", {28'd0, wgnt, rgnt}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        initSweep(100);

        // Asynchronous reset at init counter 100.
        @(negedge clk);
        checkOutput("counter at 100", 32'(ramWAddr), 32'd100);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset", {27'd0, initBusy, ramWr, wgnt != 2'b00, rgnt != 2'b00, rvalid != 2'b00},
                    {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        checkOutput("reset held", {31'd0, ramWr}, 32'd0);
        rst = 1'b1;
        initSweep(DEPTH);
        resetModel();

        // Every address reads back as zero after re-initialisation.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(2'b00, 2'b01, 8'h00, 8'h00, 16'h0, 16'h0, AW'(a), 8'h00);
            runCycle($sformatf("readback %0d", a), 1'b0, 2'b00, 2'b00, 1'b0, '0);
        end
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 8'h00, 8'h00);
        runCycle("readback last", 1'b0, 2'b00, 2'b00, 1'b1, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
